// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: cache-port request bundle plus the single downstream memory port
interface mem_port_arbiter_if #(
    parameter int N_PORTS = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    localparam int SEL_W = DATA_W / 8;
    localparam int GW    = N_PORTS > 1 ? $clog2(N_PORTS) : 1;
    logic [N_PORTS-1:0]        port_access;
    logic [N_PORTS-1:0]        port_write;
    logic [N_PORTS*ADDR_W-1:0] port_addr;
    logic [N_PORTS*2-1:0]      port_size;
    logic [N_PORTS*SEL_W-1:0]  port_sel;
    logic [N_PORTS*DATA_W-1:0] port_st_data;
    logic [N_PORTS-1:0]        port_ready;
    logic [DATA_W-1:0]         port_rdata;
    logic [GW-1:0]             grant_idx;
    logic                      mem_access;
    logic                      mem_write;
    logic [ADDR_W-1:0]         mem_a;
    logic [1:0]                mem_size;
    logic [SEL_W-1:0]          mem_sel;
    logic [DATA_W-1:0]         mem_st_data;
    logic [DATA_W-1:0]         mem_data;
    logic                      mem_ready;
    modport slave (
        input  port_access, port_write, port_addr, port_size, port_sel, port_st_data, mem_data, mem_ready,
        output port_ready, port_rdata, grant_idx, mem_access, mem_write, mem_a, mem_size, mem_sel, mem_st_data
    );
    modport master (
        output port_access, port_write, port_addr, port_size, port_sel, port_st_data, mem_data, mem_ready,
        input  port_ready, port_rdata, grant_idx, mem_access, mem_write, mem_a, mem_size, mem_sel, mem_st_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: registered N-port round-robin/fixed-priority arbiter onto one memory port
module mem_port_arbiter #(
    parameter int N_PORTS = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RR_MODE = 1
) (
    input logic clk,
    input logic rst,
    mem_port_arbiter_if.slave bus
);
    localparam int SEL_W = DATA_W / 8;
    localparam int GW    = N_PORTS > 1 ? $clog2(N_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       grant_q, grant_d, last_q, last_d, win;
    logic                mem_access_q, mem_access_d, mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
    logic [1:0]          mem_size_q, mem_size_d;
    logic [SEL_W-1:0]    mem_sel_q, mem_sel_d;
    logic [DATA_W-1:0]   mem_st_data_q, mem_st_data_d, port_rdata_q, port_rdata_d;
    logic [N_PORTS-1:0]  port_ready_q, port_ready_d;

    // k-th candidate in search order: after the last grant (RR) or by ascending index (fixed)
    function automatic int pos(input logic [GW-1:0] last, input int k);
        return RR_MODE != 0 ? (int'(last) + k) % N_PORTS : k - 1;
    endfunction

    // scanning from the back lets the earliest candidate in search order win
    always_comb begin
        win = '0;
        for (int k = N_PORTS; k >= 1; k--)
            if (bus.port_access[pos(last_q, k)]) win = GW'(pos(last_q, k));
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_d        = last_q;
        mem_access_d  = mem_access_q;
        mem_write_d   = mem_write_q;
        mem_a_d       = mem_a_q;
        mem_size_d    = mem_size_q;
        mem_sel_d     = mem_sel_q;
        mem_st_data_d = mem_st_data_q;
        port_rdata_d  = port_rdata_q;
        port_ready_d  = '0;
        unique case (state_q)
            IDLE: if (|bus.port_access) begin
                state_d       = BUSY;
                grant_d       = win;
                mem_access_d  = 1'b1;
                mem_write_d   = bus.port_write[win];
                mem_a_d       = bus.port_addr[win*ADDR_W +: ADDR_W];
                mem_size_d    = bus.port_size[win*2 +: 2];
                mem_sel_d     = bus.port_sel[win*SEL_W +: SEL_W];
                mem_st_data_d = bus.port_st_data[win*DATA_W +: DATA_W];
            end
            BUSY: if (bus.mem_ready) begin
                state_d               = RESP;
                mem_access_d          = 1'b0;
                port_rdata_d          = bus.mem_data;
                port_ready_d[grant_q] = 1'b1;
                last_d                = RR_MODE != 0 ? grant_q : last_q;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            last_q        <= GW'(N_PORTS - 1);
            mem_access_q  <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_a_q       <= '0;
            mem_size_q    <= '0;
            mem_sel_q     <= '0;
            mem_st_data_q <= '0;
            port_rdata_q  <= '0;
            port_ready_q  <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_q        <= last_d;
            mem_access_q  <= mem_access_d;
            mem_write_q   <= mem_write_d;
            mem_a_q       <= mem_a_d;
            mem_size_q    <= mem_size_d;
            mem_sel_q     <= mem_sel_d;
            mem_st_data_q <= mem_st_data_d;
            port_rdata_q  <= port_rdata_d;
            port_ready_q  <= port_ready_d;
        end
    end

    assign bus.grant_idx   = grant_q;
    assign bus.mem_access  = mem_access_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.mem_a       = mem_a_q;
    assign bus.mem_size    = mem_size_q;
    assign bus.mem_sel     = mem_sel_q;
    assign bus.mem_st_data = mem_st_data_q;
    assign bus.port_rdata  = port_rdata_q;
    assign bus.port_ready  = port_ready_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for 2-port RR, 2-port fixed-priority and 4-port RR arbiters
module tb_mem_port_arbiter;
    typedef struct {
        int          port;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clk, rst;
    logic [1:0]  p_access, p_write;
    logic [63:0] p_addr, p_st;
    logic [3:0]  p_size;
    logic [7:0]  p_sel;
    logic [3:0]  a4;
    logic [127:0] addr4;
    logic        m_ready;
    logic [31:0] m_data;
    int          checks, errors;
    exp_t        rr_q[$], fp_q[$], q4[$];

    mem_port_arbiter_if #(.N_PORTS(2)) if_rr ();
    mem_port_arbiter_if #(.N_PORTS(2)) if_fp ();
    mem_port_arbiter_if #(.N_PORTS(4)) if_4 ();

    mem_port_arbiter #(.N_PORTS(2), .RR_MODE(1)) u_rr (.clk(clk), .rst(rst), .bus(if_rr.slave));
    mem_port_arbiter #(.N_PORTS(2), .RR_MODE(0)) u_fp (.clk(clk), .rst(rst), .bus(if_fp.slave));
    mem_port_arbiter #(.N_PORTS(4), .RR_MODE(1)) u_4  (.clk(clk), .rst(rst), .bus(if_4.slave));

    assign if_rr.port_access  = p_access;
    assign if_rr.port_write   = p_write;
    assign if_rr.port_addr    = p_addr;
    assign if_rr.port_size    = p_size;
    assign if_rr.port_sel     = p_sel;
    assign if_rr.port_st_data = p_st;
    assign if_rr.mem_ready    = m_ready;
    assign if_rr.mem_data     = m_data;
    assign if_fp.port_access  = p_access;
    assign if_fp.port_write   = p_write;
    assign if_fp.port_addr    = p_addr;
    assign if_fp.port_size    = p_size;
    assign if_fp.port_sel     = p_sel;
    assign if_fp.port_st_data = p_st;
    assign if_fp.mem_ready    = m_ready;
    assign if_fp.mem_data     = m_data;
    assign if_4.port_access   = a4;
    assign if_4.port_write    = '0;
    assign if_4.port_addr     = addr4;
    assign if_4.port_size     = '1;
    assign if_4.port_sel      = '1;
    assign if_4.port_st_data  = '0;
    assign if_4.mem_ready     = m_ready;
    assign if_4.mem_data      = m_data;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        tick();
        tick();
        checks++; if (if_rr.mem_access !== 1'b0) begin errors++; $display("FAIL rst_mem_access got %b want 0", if_rr.mem_access); end
        checks++; if (if_rr.mem_write !== 1'b0) begin errors++; $display("FAIL rst_mem_write got %b want 0", if_rr.mem_write); end
        checks++; if (if_rr.mem_a !== 32'h0) begin errors++; $display("FAIL rst_mem_a got %h want 0", if_rr.mem_a); end
        checks++; if (if_rr.mem_size !== 2'b0) begin errors++; $display("FAIL rst_mem_size got %b want 0", if_rr.mem_size); end
        checks++; if (if_rr.mem_sel !== 4'h0) begin errors++; $display("FAIL rst_mem_sel got %h want 0", if_rr.mem_sel); end
        checks++; if (if_rr.mem_st_data !== 32'h0) begin errors++; $display("FAIL rst_mem_st_data got %h want 0", if_rr.mem_st_data); end
        checks++; if (if_rr.port_ready !== 2'b0) begin errors++; $display("FAIL rst_port_ready got %b want 0", if_rr.port_ready); end
        checks++; if (if_rr.port_rdata !== 32'h0) begin errors++; $display("FAIL rst_port_rdata got %h want 0", if_rr.port_rdata); end
        checks++; if (if_rr.grant_idx !== 1'b0) begin errors++; $display("FAIL rst_grant_idx got %b want 0", if_rr.grant_idx); end
        checks++; if (if_4.grant_idx !== 2'b0) begin errors++; $display("FAIL rst_grant_idx4 got %b want 0", if_4.grant_idx); end
        rst = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (if_rr.mem_access !== 1'b0 || if_fp.mem_access !== 1'b0) begin errors++; $display("FAIL idle_mem_access cycle %0d got %b/%b want 0", i, if_rr.mem_access, if_fp.mem_access); end
        end
    endtask

    task automatic test_single_load();
        exp_t e;
        p_addr[63:32] = 32'hBFC0_0100;
        p_size[3:2]   = 2'b10;
        p_sel[7:4]    = 4'hF;
        p_write       = 2'b00;
        p_access      = 2'b10;
        rr_q.push_back('{1, 32'hBFC0_0100, 32'h3C08_BFAF});
        tick();
        e = rr_q.pop_front();
        checks++; if (if_rr.mem_access !== 1'b1) begin errors++; $display("FAIL load_access got %b want 1", if_rr.mem_access); end
        checks++; if (if_rr.mem_a !== e.addr) begin errors++; $display("FAIL load_addr got %h want %h", if_rr.mem_a, e.addr); end
        checks++; if (if_rr.mem_write !== 1'b0) begin errors++; $display("FAIL load_write got %b want 0", if_rr.mem_write); end
        checks++; if (int'(if_rr.grant_idx) !== e.port) begin errors++; $display("FAIL load_grant got %0d want %0d", if_rr.grant_idx, e.port); end
        checks++; if (if_rr.mem_size !== 2'b10 || if_rr.mem_sel !== 4'hF) begin errors++; $display("FAIL load_size_sel got %b/%h want 10/f", if_rr.mem_size, if_rr.mem_sel); end
        tick();
        checks++; if (if_rr.port_ready !== 2'b00) begin errors++; $display("FAIL load_early_ready got %b want 00", if_rr.port_ready); end
        m_data  = e.data;
        m_ready = 1;
        tick();
        m_ready  = 0;
        p_access = 2'b00;
        checks++; if (if_rr.port_ready !== 2'(2'b01 << e.port)) begin errors++; $display("FAIL load_ready got %b want 10", if_rr.port_ready); end
        checks++; if (if_rr.port_rdata !== e.data) begin errors++; $display("FAIL load_rdata got %h want %h", if_rr.port_rdata, e.data); end
        checks++; if (if_rr.mem_access !== 1'b0) begin errors++; $display("FAIL load_access_drop got %b want 0", if_rr.mem_access); end
        tick();
        checks++; if (if_rr.port_ready !== 2'b00) begin errors++; $display("FAIL load_ready_pulse got %b want 00", if_rr.port_ready); end
        checks++; if (if_rr.port_rdata !== e.data) begin errors++; $display("FAIL load_rdata_hold got %h want %h", if_rr.port_rdata, e.data); end
    endtask

    task automatic test_contention();
        exp_t er, ef;
        int   n;
        int   rr_order[5] = '{0, 1, 0, 1, 1};
        int   fp_order[5] = '{0, 0, 0, 0, 1};
        p_addr   = {32'h0000_2000, 32'h0000_1000};
        p_write  = 2'b00;
        p_access = 2'b11;
        for (int t = 0; t < 5; t++) begin
            rr_q.push_back('{rr_order[t], 32'h1000 * (rr_order[t] + 1), 32'hD000_0000 + t});
            fp_q.push_back('{fp_order[t], 32'h1000 * (fp_order[t] + 1), 32'hD000_0000 + t});
        end
        for (int t = 0; t < 5; t++) begin
            n = 0;
            while (!if_rr.mem_access && n < 10) begin
                tick();
                n++;
            end
            checks++; if (if_rr.mem_access !== 1'b1) begin errors++; $display("FAIL cont_timeout txn %0d got %b want 1", t, if_rr.mem_access); break; end
            er = rr_q.pop_front();
            ef = fp_q.pop_front();
            checks++; if (int'(if_rr.grant_idx) !== er.port) begin errors++; $display("FAIL rr_grant txn %0d got %0d want %0d", t, if_rr.grant_idx, er.port); end
            checks++; if (if_rr.mem_a !== er.addr) begin errors++; $display("FAIL rr_addr txn %0d got %h want %h", t, if_rr.mem_a, er.addr); end
            checks++; if (int'(if_fp.grant_idx) !== ef.port) begin errors++; $display("FAIL fp_grant txn %0d got %0d want %0d", t, if_fp.grant_idx, ef.port); end
            checks++; if (if_fp.mem_a !== ef.addr) begin errors++; $display("FAIL fp_addr txn %0d got %h want %h", t, if_fp.mem_a, ef.addr); end
            tick();
            m_data  = er.data;
            m_ready = 1;
            tick();
            m_ready = 0;
            checks++; if (if_rr.port_ready !== 2'(2'b01 << er.port)) begin errors++; $display("FAIL rr_ready txn %0d got %b want port %0d", t, if_rr.port_ready, er.port); end
            checks++; if (if_fp.port_ready !== 2'(2'b01 << ef.port)) begin errors++; $display("FAIL fp_ready txn %0d got %b want port %0d", t, if_fp.port_ready, ef.port); end
            checks++; if (if_rr.port_rdata !== er.data) begin errors++; $display("FAIL rr_rdata txn %0d got %h want %h", t, if_rr.port_rdata, er.data); end
            if (t == 3) p_access = 2'b10;
        end
        p_access = 2'b00;
        tick();
        tick();
        m_ready = 1;
        tick();
        m_ready = 0;
        checks++; if (if_rr.port_ready !== 2'b00 || if_rr.mem_access !== 1'b0) begin errors++; $display("FAIL idle_ready_ignored got %b/%b want 00/0", if_rr.port_ready, if_rr.mem_access); end
        tick();
        checks++; if (if_rr.port_ready !== 2'b00) begin errors++; $display("FAIL idle_ready_late got %b want 00", if_rr.port_ready); end
    endtask

    task automatic test_store_latch();
        exp_t e;
        p_write       = 2'b01;
        p_addr[31:0]  = 32'h8000_0010;
        p_sel[3:0]    = 4'b0011;
        p_st[31:0]    = 32'h0000_BEEF;
        p_size[1:0]   = 2'b01;
        p_access      = 2'b01;
        rr_q.push_back('{0, 32'h8000_0010, 32'hCAFE_0001});
        tick();
        e = rr_q.pop_front();
        checks++; if (if_rr.mem_access !== 1'b1 || if_rr.mem_write !== 1'b1) begin errors++; $display("FAIL st_access_write got %b/%b want 1/1", if_rr.mem_access, if_rr.mem_write); end
        checks++; if (if_rr.mem_a !== e.addr) begin errors++; $display("FAIL st_addr got %h want %h", if_rr.mem_a, e.addr); end
        checks++; if (if_rr.mem_sel !== 4'b0011 || if_rr.mem_size !== 2'b01) begin errors++; $display("FAIL st_sel_size got %b/%b want 0011/01", if_rr.mem_sel, if_rr.mem_size); end
        checks++; if (if_rr.mem_st_data !== 32'h0000_BEEF) begin errors++; $display("FAIL st_data got %h want 0000beef", if_rr.mem_st_data); end
        p_addr[31:0] = 32'hDEAD_0000;
        p_sel[3:0]   = 4'hF;
        p_st[31:0]   = 32'h1234_5678;
        p_write      = 2'b00;
        p_size[1:0]  = 2'b10;
        p_access     = 2'b00;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (if_rr.mem_a !== e.addr || if_rr.mem_sel !== 4'b0011) begin errors++; $display("FAIL st_hold_addr_sel cycle %0d got %h/%b want %h/0011", i, if_rr.mem_a, if_rr.mem_sel, e.addr); end
            checks++; if (if_rr.mem_st_data !== 32'h0000_BEEF || if_rr.mem_write !== 1'b1 || if_rr.mem_access !== 1'b1) begin errors++; $display("FAIL st_hold_data cycle %0d got %h/%b/%b want 0000beef/1/1", i, if_rr.mem_st_data, if_rr.mem_write, if_rr.mem_access); end
        end
        m_data  = e.data;
        m_ready = 1;
        tick();
        m_ready = 0;
        checks++; if (if_rr.port_ready !== 2'b01) begin errors++; $display("FAIL st_ready got %b want 01", if_rr.port_ready); end
        checks++; if (if_rr.port_rdata !== e.data) begin errors++; $display("FAIL st_rdata got %h want %h", if_rr.port_rdata, e.data); end
        tick();
        checks++; if (if_rr.port_ready !== 2'b00) begin errors++; $display("FAIL st_ready_pulse got %b want 00", if_rr.port_ready); end
    endtask

    task automatic test_reset_midop();
        exp_t e;
        int   n;
        p_addr[31:0] = 32'h0000_0040;
        p_access     = 2'b01;
        tick();
        checks++; if (if_rr.mem_access !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", if_rr.mem_access); end
        rst      = 1;
        m_ready  = 1;
        m_data   = 32'hFFFF_FFFF;
        p_access = 2'b00;
        tick();
        rst     = 0;
        m_ready = 0;
        checks++; if (if_rr.mem_access !== 1'b0 || if_rr.port_ready !== 2'b00) begin errors++; $display("FAIL mid_rst got %b/%b want 0/00", if_rr.mem_access, if_rr.port_ready); end
        checks++; if (if_rr.port_rdata !== 32'h0) begin errors++; $display("FAIL mid_rst_rdata got %h want 0", if_rr.port_rdata); end
        tick();
        checks++; if (if_rr.port_ready !== 2'b00 || if_rr.mem_access !== 1'b0) begin errors++; $display("FAIL mid_rst_idle got %b/%b want 00/0", if_rr.port_ready, if_rr.mem_access); end
        for (int i = 0; i < 4; i++) addr4[i*32 +: 32] = 32'h4000_0000 + i;
        a4 = 4'b1010;
        q4.push_back('{1, 32'h4000_0001, 32'h0000_0011});
        q4.push_back('{3, 32'h4000_0003, 32'h0000_0033});
        for (int t = 0; t < 2; t++) begin
            n = 0;
            while (!if_4.mem_access && n < 10) begin
                tick();
                n++;
            end
            checks++; if (if_4.mem_access !== 1'b1) begin errors++; $display("FAIL n4_timeout txn %0d got %b want 1", t, if_4.mem_access); break; end
            e = q4.pop_front();
            checks++; if (int'(if_4.grant_idx) !== e.port) begin errors++; $display("FAIL n4_grant txn %0d got %0d want %0d", t, if_4.grant_idx, e.port); end
            checks++; if (if_4.mem_a !== e.addr) begin errors++; $display("FAIL n4_addr txn %0d got %h want %h", t, if_4.mem_a, e.addr); end
            m_data  = e.data;
            m_ready = 1;
            tick();
            m_ready = 0;
            checks++; if (if_4.port_ready !== 4'(4'b0001 << e.port)) begin errors++; $display("FAIL n4_ready txn %0d got %b want port %0d", t, if_4.port_ready, e.port); end
            checks++; if (if_4.port_rdata !== e.data) begin errors++; $display("FAIL n4_rdata txn %0d got %h want %h", t, if_4.port_rdata, e.data); end
        end
        a4 = 4'b0000;
        tick();
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1;
        p_access = '0;
        p_write  = '0;
        p_addr   = '0;
        p_size   = '0;
        p_sel    = '0;
        p_st     = '0;
        a4       = '0;
        addr4    = '0;
        m_ready  = 0;
        m_data   = '0;
        test_reset();
        test_single_load();
        test_contention();
        test_store_latch();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
